// File: rtl/des_pkg.sv
// Shared DES constants: half/subkey widths, S-box geometry, round-tag width
// and the E bit-selection table (FIPS bit numbering, bit 1 = MSB).
package des_pkg;

  localparam int HALF_W    = 32;
  localparam int SUBKEY_W  = 48;
  localparam int SBOX_IN_W = 6;
  localparam int NUM_SBOX  = 8;
  localparam int TAG_W     = 5;

  // Output bit i (1..48) takes R bit E_TABLE[i-1].
  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

endpackage

// File: rtl/des_expand_keymix_if.sv
// Beat-level bus of the expand/key-mix stage: input channel (R, subkey,
// block start) and output channel (S-box addresses, round tag).
interface des_expand_keymix_if;
  import des_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [HALF_W-1:0]   r_in;
  logic [SUBKEY_W-1:0] subkey;
  logic                blk_start;
  logic                out_valid;
  logic                out_ready;
  logic [SUBKEY_W-1:0] sbox_addr;
  logic [TAG_W-1:0]    round_o;
  logic                last_o;

  // Producer/consumer side (drives beats in, accepts results).
  modport master (
    output in_valid, r_in, subkey, blk_start, out_ready,
    input  in_ready, out_valid, sbox_addr, round_o, last_o
  );

  // The stage itself.
  modport slave (
    input  in_valid, r_in, subkey, blk_start, out_ready,
    output in_ready, out_valid, sbox_addr, round_o, last_o
  );
endinterface

// File: rtl/des_elastic_buf.sv
// DEPTH-entry valid/ready FIFO. in_ready is a flop (no path from out_ready);
// out_data reads zero while empty so the consumer never sees stale beats.
module des_elastic_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          ready_q;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = in_valid & ready_q;
  assign pop       = (count != '0) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (count != '0);
  assign out_data  = (count != '0) ? mem[rd_ptr] : '0;

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and the registered ready flag (0 while in reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count   <= count_next;
      ready_q <= (count_next < CW'(DEPTH));
    end
  end

  // Payload storage; validity is tracked by count, so no reset needed here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/des_expand_keymix.sv
// DES round front end: E-expansion of R, XOR with the subkey, buffered as
// eight 6-bit S-box addresses. Optional round tagging under the macro
// DES_ROUND_TAG_EN; without it round_o/last_o are held at zero.
module des_expand_keymix
  import des_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ROUNDS = 16
) (
  input  logic clk,
  input  logic rst_n,
  des_expand_keymix_if.slave bus
);

  logic [SUBKEY_W-1:0] expanded;
  logic [SUBKEY_W-1:0] mixed;

  // FIPS bit i of an N-bit vector sits at index N-i.
  for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_expand
    assign expanded[SUBKEY_W-1-gi] = bus.r_in[HALF_W - E_TABLE[gi]];
  end

  assign mixed = expanded ^ bus.subkey;

`ifdef DES_ROUND_TAG_EN
  logic [TAG_W-1:0]          cnt_reg;
  logic [TAG_W-1:0]          tag_next;
  logic                      push;
  logic [SUBKEY_W+TAG_W-1:0] buf_out;

  assign push = bus.in_valid & bus.in_ready;

  // Tag for the beat being offered: restart at 1 on block start, else advance and wrap.
  always_comb begin
    tag_next = TAG_W'(1);
    if (!bus.blk_start && (cnt_reg < TAG_W'(ROUNDS)))
      tag_next = cnt_reg + 1'b1;
  end

  // Round counter remembers the tag of the last accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_reg <= '0;
    else if (push) cnt_reg <= tag_next;
  end

  des_elastic_buf #(.DEPTH(DEPTH), .W(SUBKEY_W + TAG_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({mixed, tag_next}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (buf_out)
  );

  assign bus.sbox_addr = buf_out[SUBKEY_W+TAG_W-1:TAG_W];
  assign bus.round_o   = buf_out[TAG_W-1:0];
  assign bus.last_o    = bus.out_valid & (buf_out[TAG_W-1:0] == TAG_W'(ROUNDS));
`else
  logic unused_cfg;

  // Block start and round count only matter when tagging is built in.
  assign unused_cfg = bus.blk_start ^ (ROUNDS == 0);

  des_elastic_buf #(.DEPTH(DEPTH), .W(SUBKEY_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (mixed),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.sbox_addr)
  );

  assign bus.round_o = '0;
  assign bus.last_o  = 1'b0;
`endif

endmodule

// File: tb/tb_des_expand_keymix.sv
// Bench for des_expand_keymix: directed DES vectors plus randomized traffic
// against a queue-based reference of the expansion, FIFO and round tags.
module tb_des_expand_keymix;

  localparam int DEPTH  = 2;
  localparam int ROUNDS = 16;
`ifdef DES_ROUND_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  typedef struct {
    logic [47:0] addr;
    int          tag;
  } beat_t;

  logic clk;
  logic rst_n;
  des_expand_keymix_if bus ();

  des_expand_keymix #(.DEPTH(DEPTH), .ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  beat_t       q[$];
  int          model_cnt = 0;
  bit          rdy_model = 1'b0;
  bit          last_push;
  logic [47:0] pop_addr[$];
  int          pop_round[$];
  int          pop_last[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // E expansion from the table's row structure: row r, col c reads R bit 4r+c (mod 32, 1-based).
  function automatic logic [47:0] ref_mix(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] res;
    int row, col, src;
    res = '0;
    for (int i = 1; i <= 48; i++) begin
      row = (i - 1) / 6;
      col = (i - 1) % 6;
      src = ((4 * row + col - 1 + 32) % 32) + 1;
      res[48-i] = r[32-src] ^ k[48-i];
    end
    return res;
  endfunction

  function automatic int exp_round(input int tag);
    return TAG_EN ? tag : 0;
  endfunction

  function automatic int exp_last(input int tag);
    return (TAG_EN && tag == ROUNDS) ? 1 : 0;
  endfunction

  // One clock: drive inputs at the falling edge, check outputs against the
  // model, predict the transfers of the next rising edge, advance.
  task automatic tick(input bit v, input logic [31:0] r, input logic [47:0] k,
                      input bit bs, input bit ordy);
    bit    exp_valid, do_push, do_pop;
    beat_t b;
    bus.in_valid  = v;
    bus.r_in      = r;
    bus.subkey    = k;
    bus.blk_start = bs;
    bus.out_ready = ordy;
    exp_valid = (q.size() != 0);
    check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    check("in_ready", 64'(bus.in_ready), 64'(rdy_model));
    if (exp_valid) begin
      check("sbox_addr", 64'(bus.sbox_addr), 64'(q[0].addr));
      check("round_o", 64'(bus.round_o), 64'(exp_round(q[0].tag)));
      check("last_o", 64'(bus.last_o), 64'(exp_last(q[0].tag)));
    end
    do_pop  = exp_valid && ordy;
    do_push = v && rdy_model;
    if (do_pop) begin
      pop_addr.push_back(bus.sbox_addr);
      pop_round.push_back(int'(bus.round_o));
      pop_last.push_back(int'(bus.last_o));
      void'(q.pop_front());
    end
    if (do_push) begin
      b.addr = ref_mix(r, k);
      b.tag  = bs ? 1 : (model_cnt % ROUNDS) + 1;
      model_cnt = b.tag;
      q.push_back(b);
    end
    rdy_model = (q.size() < DEPTH);
    last_push = do_push;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    pop_addr.delete();
    pop_round.delete();
    pop_last.delete();
  endtask

  initial begin
    logic [31:0] r;
    logic [47:0] k;
    logic [63:0] wide;
    logic [31:0] bp_r[3];
    logic [47:0] bp_k[3];

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.r_in = '0; bus.subkey = '0;
    bus.blk_start = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sbox_addr", 64'(bus.sbox_addr), 64'd0);
    check("rst_round_o", 64'(bus.round_o), 64'd0);
    check("rst_last_o", 64'(bus.last_o), 64'd0);
    rst_n = 1'b1;
    tick(0, '0, '0, 0, 1);
    check("ready_after_release", 64'(bus.in_ready), 64'd1);

    // Textbook round-1 vector.
    tick(1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1, 1);
    check("kat_valid", 64'(bus.out_valid), 64'd1);
    check("kat_addr", 64'(bus.sbox_addr), 64'h6117BA866527);
    wide = 64'(bus.sbox_addr);
    check("kat_s2", 64'(wide[41:36]), 64'h11);
    check("kat_round", 64'(bus.round_o), TAG_EN ? 64'd1 : 64'd0);
    check("kat_last", 64'(bus.last_o), 64'd0);

    // All-zero, all-one and E wrap-around bits.
    tick(1, 32'h0, 48'h0, 0, 1);
    check("zero_addr", 64'(bus.sbox_addr), 64'h0);
    tick(1, 32'hFFFFFFFF, 48'h0, 0, 1);
    check("ones_addr", 64'(bus.sbox_addr), 64'hFFFFFFFFFFFF);
    tick(1, 32'h80000001, 48'h0, 0, 1);
    check("wrap_addr", 64'(bus.sbox_addr), 64'hC00000000003);
    repeat (2) tick(0, '0, '0, 0, 1);

    // Backpressure: two beats fill the buffer, the third waits.
    for (int i = 0; i < 3; i++) begin
      bp_r[i] = $urandom;
      wide    = {$urandom, $urandom};
      bp_k[i] = wide[47:0];
    end
    clear_logs();
    tick(1, bp_r[0], bp_k[0], 1, 0);
    tick(1, bp_r[1], bp_k[1], 0, 0);
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    tick(1, bp_r[2], bp_k[2], 0, 0);
    check("bp_third_held", 64'(last_push), 64'd0);
    for (int t = 0; t < 8; t++) begin
      tick(1, bp_r[2], bp_k[2], 0, 1);
      if (last_push) break;
    end
    check("bp_third_taken", 64'(last_push), 64'd1);
    repeat (4) tick(0, '0, '0, 0, 1);
    check("bp_count", 64'(pop_addr.size()), 64'd3);
    for (int i = 0; i < 3 && i < pop_addr.size(); i++)
      check($sformatf("bp_order%0d", i), 64'(pop_addr[i]), 64'(ref_mix(bp_r[i], bp_k[i])));

    // 17 back-to-back beats, block start only on the first.
    clear_logs();
    for (int i = 0; i < 17; i++) begin
      r = $urandom;
      wide = {$urandom, $urandom};
      tick(1, r, wide[47:0], i == 0, 1);
    end
    repeat (3) tick(0, '0, '0, 0, 1);
    check("rnd_count", 64'(pop_round.size()), 64'd17);
    for (int i = 0; i < 17 && i < pop_round.size(); i++) begin
      check($sformatf("rnd_tag%0d", i), 64'(pop_round[i]), TAG_EN ? 64'((i % 16) + 1) : 64'd0);
      check($sformatf("rnd_last%0d", i), 64'(pop_last[i]), (TAG_EN && i == 15) ? 64'd1 : 64'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      wide = {$urandom, $urandom};
      tick($urandom_range(0, 3) != 0, r, wide[47:0],
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (4) tick(0, '0, '0, 0, 1);

    // Reset with two beats buffered discards them.
    tick(1, 32'h12345678, 48'hABCDEF012345, 1, 0);
    tick(1, 32'h9ABCDEF0, 48'h0123456789AB, 0, 0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_sbox_addr", 64'(bus.sbox_addr), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_round_o", 64'(bus.round_o), 64'd0);
    q.delete();
    model_cnt = 0;
    rdy_model = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (4) tick(0, '0, '0, 0, 1);
    check("mid_rst_no_beats", 64'(pop_addr.size()), 64'd0);
    // First beat after reset without block start still gets tag 1.
    tick(1, 32'h0F0F0F0F, 48'h0, 0, 1);
    check("post_rst_round", 64'(bus.round_o), TAG_EN ? 64'd1 : 64'd0);
    repeat (2) tick(0, '0, '0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
